queue_reader: RTL

//  Read-side controller for the 6-bit RAM queue on the board platform. Issues single pop

---
 rtl/queue_pkg.sv | 30 +++
 rtl/queue_reader_if.sv | 30 +++
 rtl/edge_detect.sv | 22 ++
 rtl/queue_reader.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/queue_pkg.sv
// Shared definitions for the RAM-queue board platform: FSM encoding, queue command values
// and default widths, plus a helper for sizing down-counters.
package queue_pkg;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_HOLD    = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE    = S_IDLE,
        ST_ISSUE   = S_ISSUE,
        ST_WAIT    = S_WAIT,
        ST_CAPTURE = S_CAPTURE,
        ST_HOLD    = S_HOLD
    } state_t;

    localparam logic CMD_POP  = 1'b0;
    localparam logic CMD_PUSH = 1'b1;

    localparam int DATA_W_DEF = 6;
    localparam int ADDR_W_DEF = 4;

    // Width of a counter that must hold 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/queue_reader_if.sv
// Pins between the queue reader, the queue top and the display logic.
// master = reader side, slave = queue/display side.
interface queue_reader_if #(
    parameter int DATA_WIDTH = 6,
    parameter int ADDR_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
);
    logic                  q_active;
    logic                  q_cmd;
    logic [DATA_WIDTH-1:0] q_data;
    logic [ADDR_WIDTH-1:0] q_addr;
    logic                  q_underflow;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_valid;
    logic [CNT_WIDTH-1:0]  rd_count;
    logic                  empty_seen;
    logic                  busy;

    modport master (
        output q_active, q_cmd, rd_data, rd_addr, rd_valid, rd_count, empty_seen, busy,
        input  q_data, q_addr, q_underflow
    );

    modport slave (
        input  q_active, q_cmd, rd_data, rd_addr, rd_valid, rd_count, empty_seen, busy,
        output q_data, q_addr, q_underflow
    );

endinterface

// File: rtl/edge_detect.sv
// Rising-edge pulse on a level input; pulse is combinational on the cycle the level rises.
// The history flop resets high so a level already high through reset is not a new edge.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic i_sig,
    output logic o_rise
);

    logic r_sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig_q <= 1'b1;
        end else begin
            r_sig_q <= i_sig;
        end
    end

    assign o_rise = i_sig & ~r_sig_q;

endmodule

// File: rtl/queue_reader.sv
// Read-side controller: one pop per trigger edge, or auto-drain every 1+READ_LAT+HOLD_CYCLES
// cycles until underflow. Captured word/address held in registers; edges while busy are dropped.
module queue_reader
    import queue_pkg::*;
#(
    parameter int DATA_WIDTH  = DATA_W_DEF,
    parameter int ADDR_WIDTH  = ADDR_W_DEF,
    parameter int READ_LAT    = 1,
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_WIDTH   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_trigger,
    input  logic            i_auto_mode,
    queue_reader_if.master  bus
);

    localparam int LAT_W  = cnt_width(READ_LAT - 1);
    localparam int HOLD_W = cnt_width(HOLD_CYCLES - 1);
    localparam logic [LAT_W-1:0]  LAT_LOAD  = LAT_W'(READ_LAT - 1);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [LAT_W-1:0]      r_lat_cnt;
    logic [LAT_W-1:0]      w_lat_cnt_nxt;
    logic [HOLD_W-1:0]     r_hold_cnt;
    logic [HOLD_W-1:0]     w_hold_cnt_nxt;
    logic                  w_edge;
    logic                  w_capture;
    logic                  w_set_empty;
    logic                  w_clr_empty;

    logic                  r_q_active;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [ADDR_WIDTH-1:0] r_rd_addr;
    logic                  r_rd_valid;
    logic [CNT_WIDTH-1:0]  r_rd_count;
    logic                  r_empty_seen;
    logic                  r_busy;

    edge_detect u_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_sig  (i_trigger),
        .o_rise (w_edge)
    );

    always_comb begin
        w_state_nxt    = r_state;
        w_lat_cnt_nxt  = r_lat_cnt;
        w_hold_cnt_nxt = r_hold_cnt;
        w_capture      = 1'b0;
        w_set_empty    = 1'b0;
        w_clr_empty    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_edge) begin
                    w_state_nxt = ST_ISSUE;
                    w_clr_empty = 1'b1;
                end
            end
            ST_ISSUE: begin
                w_lat_cnt_nxt = LAT_LOAD;
                w_state_nxt   = (READ_LAT == 1) ? ST_CAPTURE : ST_WAIT;
            end
            ST_WAIT: begin
                // Entered with READ_LAT-1 loaded, so this spends READ_LAT-1 cycles here.
                w_lat_cnt_nxt = r_lat_cnt - 1'b1;
                if (r_lat_cnt <= LAT_W'(1)) begin
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (bus.q_underflow) begin
                    w_set_empty = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_capture      = 1'b1;
                    w_hold_cnt_nxt = HOLD_LOAD;
                    w_state_nxt    = i_auto_mode ? ST_HOLD : ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (!i_auto_mode) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_hold_cnt == '0) begin
                    w_state_nxt = ST_ISSUE;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt - 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_lat_cnt  <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_lat_cnt  <= w_lat_cnt_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    // Strobes are registered from the next-state decode so they line up with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q_active   <= 1'b0;
            r_busy       <= 1'b0;
            r_rd_valid   <= 1'b0;
            r_rd_data    <= '0;
            r_rd_addr    <= '0;
            r_rd_count   <= '0;
            r_empty_seen <= 1'b0;
        end else begin
            r_q_active <= (w_state_nxt == ST_ISSUE);
            r_busy     <= (w_state_nxt != ST_IDLE);
            r_rd_valid <= w_capture;
            if (w_capture) begin
                r_rd_data  <= bus.q_data;
                r_rd_addr  <= bus.q_addr;
                r_rd_count <= r_rd_count + 1'b1;
            end
            if (w_set_empty) begin
                r_empty_seen <= 1'b1;
            end else if (w_clr_empty) begin
                r_empty_seen <= 1'b0;
            end
        end
    end

    assign bus.q_active   = r_q_active;
    assign bus.q_cmd      = CMD_POP;
    assign bus.rd_data    = r_rd_data;
    assign bus.rd_addr    = r_rd_addr;
    assign bus.rd_valid   = r_rd_valid;
    assign bus.rd_count   = r_rd_count;
    assign bus.empty_seen = r_empty_seen;
    assign bus.busy       = r_busy;

endmodule
